// File: rtl/sequence_detector_pkg.sv
// Shared types and constants for the 12-bit sync-word detector
// (pattern 1110_1101_1011, MSB arrives first).
package sequence_detector_pkg;

   // Sk: the last k bits received match the first k pattern bits (longest such k)
   typedef enum logic [3:0] {
      S0  = 4'd0,
      S1  = 4'd1,
      S2  = 4'd2,
      S3  = 4'd3,
      S4  = 4'd4,
      S5  = 4'd5,
      S6  = 4'd6,
      S7  = 4'd7,
      S8  = 4'd8,
      S9  = 4'd9,
      S10 = 4'd10,
      S11 = 4'd11,
      S12 = 4'd12
   } state_t;

   localparam logic [11:0] PATTERN     = 12'b1110_1101_1011;
   localparam int unsigned PATTERN_LEN = 12;

endpackage

// File: rtl/sequence_detector_if.sv
// Serial link between a bit source and the sync-word detector:
// one data bit per clock and the detect pulse coming back.
interface sequence_detector_if;
   logic x_i;
   logic det_o;

   modport master (output x_i, input det_o);
   modport slave  (input x_i, output det_o);
endinterface

// File: rtl/sequence_detector.sv
// Moore FSM that pulses det_o for one cycle each time the last 12 serial bits
// equal the sync word; overlapping occurrences are detected.
module sequence_detector
   import sequence_detector_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   sequence_detector_if.slave bus
);

   state_t state_r;
   state_t next_s;
   logic   det_r;

   // Next-state: on a mismatch fall back to the longest border still valid.
   // S12 behaves as S2 because the pattern's longest proper border is "11".
   always_comb begin
      next_s = S0;
      case (state_r)
         S0:      next_s = bus.x_i ? S1  : S0;
         S1:      next_s = bus.x_i ? S2  : S0;
         S2:      next_s = bus.x_i ? S3  : S0;
         S3:      next_s = bus.x_i ? S3  : S4;
         S4:      next_s = bus.x_i ? S5  : S0;
         S5:      next_s = bus.x_i ? S6  : S0;
         S6:      next_s = bus.x_i ? S3  : S7;
         S7:      next_s = bus.x_i ? S8  : S0;
         S8:      next_s = bus.x_i ? S9  : S0;
         S9:      next_s = bus.x_i ? S3  : S10;
         S10:     next_s = bus.x_i ? S11 : S0;
         S11:     next_s = bus.x_i ? S12 : S0;
         S12:     next_s = bus.x_i ? S3  : S0;
         default: next_s = S0;
      endcase
   end

   // State register with det_o registered alongside so it tracks state == S12
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= S0;
         det_r   <= 1'b0;
      end else begin
         state_r <= next_s;
         det_r   <= (next_s == S12);
      end
   end

   assign bus.det_o = det_r;

endmodule

// File: tb/tb_sequence_detector.sv
// Self-checking bench: a 12-bit shift-register compare model scores det_o
// every cycle, plus directed pulse-timing checks.
module tb_sequence_detector;

   localparam logic [11:0] REF_PAT = 12'b1110_1101_1011;

   logic clk;
   logic reset;

   sequence_detector_if bus ();

   sequence_detector dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   logic [11:0] hist   = 12'd0;
   int          nvalid = 0;
   int          pulses[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   // One clock: drive on the falling edge, score just after the rising edge.
   task automatic step(input logic b, input logic r);
      logic exp_det;
      @(negedge clk);
      bus.x_i = b;
      reset   = r;
      @(posedge clk);
      #1;
      cyc++;
      if (r) begin
         hist   = 12'd0;
         nvalid = 0;
      end else begin
         hist = {hist[10:0], b};
         if (nvalid < 12) nvalid++;
      end
      exp_det = (nvalid >= 12) && (hist == REF_PAT);
      chk("det", 32'(bus.det_o), 32'(exp_det));
      if (bus.det_o === 1'b1) pulses.push_back(cyc);
   endtask

   task automatic send(input logic [31:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b0);
   endtask

   function automatic int last_pulse();
      return (pulses.size() > 0) ? pulses[pulses.size() - 1] : -1;
   endfunction

   initial begin
      int n0;
      int c0;
      int gap;
      bus.x_i = 1'b0;
      reset   = 1'b1;

      // reset held two cycles, then idle zeros
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      chk("reset_state", 32'(dut.state_r), 32'd0);
      send(32'b00000, 5);
      chk("idle_state", 32'(dut.state_r), 32'd0);
      chk("idle_cnt", 32'(pulses.size()), 32'd0);

      // clean pattern: pulse on the edge sampling the 12th bit
      c0 = cyc;
      send(32'(REF_PAT), 12);
      chk("pat_pos", 32'(last_pulse()), 32'(c0 + 12));
      step(1'b0, 1'b0);

      // overlap: second pulse exactly 10 cycles later
      n0 = pulses.size();
      send(32'(REF_PAT), 12);
      send(32'b1011011011, 10);
      gap = (pulses.size() - n0 >= 2) ? pulses[n0 + 1] - pulses[n0] : -1;
      chk("overlap_gap", 32'(gap), 32'd10);
      chk("overlap_cnt", 32'(pulses.size() - n0), 32'd2);
      send(32'b00, 2);

      // near miss, then a reset colliding with the 12th bit
      n0 = pulses.size();
      send(32'b111011011010, 12);
      send(32'b11101101101, 11);
      step(1'b1, 1'b1);
      chk("nearmiss_cnt", 32'(pulses.size() - n0), 32'd0);
      chk("post_reset_state", 32'(dut.state_r), 32'd0);
      step(1'b0, 1'b0);

      // extra leading ones exercise the S3 self-loop
      n0 = pulses.size();
      c0 = cyc;
      send(32'b1111_1110_1101_1011, 16);
      chk("lead1_cnt", 32'(pulses.size() - n0), 32'd1);
      chk("lead1_pos", 32'(last_pulse()), 32'(c0 + 16));
      send(32'b000, 3);

      // random bits, then a clean pattern, then idle
      for (int i = 0; i < 20; i++) step(1'($urandom_range(0, 1)), 1'b0);
      c0 = cyc;
      send(32'(REF_PAT), 12);
      chk("rand_tail_pos", 32'(last_pulse()), 32'(c0 + 12));
      send(32'b00000, 5);

      // longer run biased toward ones, with occasional resets
      for (int i = 0; i < 600; i++) begin
         logic b;
         logic r;
         b = ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 99) == 0);
         step(b, r);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sequence_detector.md
# sequence_detector

Serial bit-stream pattern detector. Samples one input bit per clock and pulses a detect flag whenever the last 12 bits received equal the fixed pattern 1110_1101_1011, with the leftmost (MSB) bit arriving first. Overlapping occurrences are detected. It sits behind a serial data source as a framing/sync-word detector.

## Interface
- No parameters; pattern (12'b1110_1101_1011) and length (12) are fixed constants.
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising edge of clk.
- x_i  input  1  serial data bit, sampled on each rising edge.
- det_o  output  1  detect pulse; high for one cycle per pattern occurrence.

## Operation
- Moore FSM with 13 states, S0..S12; Sk means "the last k bits equal the first k pattern bits" (longest such k).
- Pattern bits in arrival order: 1,1,1,0,1,1,0,1,1,0,1,1.
- Transitions, written as state: next state on x_i=0 / next state on x_i=1:
  - S0: S0 / S1
  - S1: S0 / S2
  - S2: S0 / S3
  - S3: S4 / S3
  - S4: S0 / S5
  - S5: S0 / S6
  - S6: S7 / S3
  - S7: S0 / S8
  - S8: S0 / S9
  - S9: S10 / S3
  - S10: S0 / S11
  - S11: S0 / S12
  - S12: S0 / S3
- S12 behaves as S2, because the longest proper border of the pattern is "11". This gives the overlap: after a match, 10 more bits (1011011011) complete the next match.
- det_o = 1 exactly when the state is S12. It is a registered output, updated on the same edge as the state register, so it is glitch-free.
- S12 cannot be entered on two consecutive cycles, so det_o is always a single-cycle pulse.
- reset has priority over x_i.
  - On any edge with reset=1: state to S0, det_o to 0.
  - Asserting reset mid-sequence discards all partial-match progress.
- Unused state encodings (13..15) return to S0 on the next edge.

## Timing
- After reset deassertion, the first bit is sampled on the next rising edge.
- Latency: det_o rises at the rising edge that samples the 12th pattern bit. It stays high until the following edge.
- No handshake; one bit is consumed per cycle, every cycle.
- Reset values: state S0, det_o 0.
- Minimum spacing between pulses is 10 cycles (overlap case).
- Minimum spacing between non-overlapping back-to-back patterns is 12 cycles.

## Structure
- Shared package sequence_detector_pkg holds:
  - the state enum state_t (4-bit, S0..S12);
  - PATTERN = 12'b1110_1101_1011;
  - PATTERN_LEN = 12.
- Single module: one state register, one explicit next-state case statement covering all 13 states plus a default, and the registered det_o.
- No sub-module is needed.
- The bench carries an independent 12-bit shift-register compare model as scoreboard.

## Test plan
- Reset held 2 cycles, then 5 zeros -> det_o stays 0; state S0 throughout.
- 5 zeros then 111011011011 -> det_o = 1 for exactly the one cycle following the edge that samples the 12th bit.
- Pattern immediately followed by 1011011011 -> second det_o pulse exactly 10 cycles after the first.
- Near-miss 111011011010, and 11101101101 followed by reset=1 on the 12th bit's edge -> det_o never asserts; state S0 after the reset.
- Extra leading ones, 1111_1110_1101_1011 -> exactly one det_o pulse, after the final bit (S3 self-loop).
- 20 random bits, then a clean pattern, then 5 idle cycles -> det_o matches the shift-register scoreboard on every cycle, with a pulse at the end of the clean pattern.
